// File: rtl/input_conditioner.sv
// Debounced pushbutton pulses with DAS/ARR auto-repeat for left/right, plus the gravity tick.
// Press pulse is high DEBOUNCE_CYCLES+2 edges after the first low sample; all outputs registered, no backpressure.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DAS_CYCLES      = 8000000,
  parameter int ARR_CYCLES      = 2500000,
  parameter int GRAV_CYCLES     = 25000000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [2:0] key_n,
  input  logic       grav_en,
  output logic       left_final,
  output logic       right_final,
  output logic       rot_final,
  output logic       tick_gravity,
  output logic       blink_g
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
  localparam int RW   = $clog2(RMAX + 1);
  localparam int GW   = $clog2(GRAV_CYCLES + 1);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DAS_LAST  = RW'(DAS_CYCLES - 1);
  localparam logic [RW-1:0] ARR_LAST  = RW'(ARR_CYCLES - 1);
  localparam logic [GW-1:0] GRAV_LAST = GW'(GRAV_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;

  logic [2:0] sync1, sync2;
  logic [2:0] stable, stable_d;
  logic [2:0] press;
  logic [2:1] rpt_pulse;
  logic [GW-1:0] grav_cnt;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      sync1    <= 3'b111;
      sync2    <= 3'b111;
      stable_d <= 3'b111;
    end else begin
      sync1    <= key_n;
      sync2    <= sync1;
      stable_d <= stable;
    end
  end

  // stable holds the key level: 1 = released, 0 = pressed
  assign press = stable_d & ~stable;

  for (genvar i = 0; i < 3; i++) begin : g_db
    logic          stable_q;
    logic [DW-1:0] db_cnt;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
        stable_q <= 1'b1;
        db_cnt   <= '0;
      end else if (sync2[i] == stable_q) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        stable_q <= sync2[i];
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end

    assign stable[i] = stable_q;
  end

  // Index 1 = right, 2 = left; one shared counter times both the DAS and ARR phases
  for (genvar j = 1; j < 3; j++) begin : g_rpt
    rpt_state_t    state;
    logic [RW-1:0] rpt_cnt;
    logic          pulse_q;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
        state   <= IDLE;
        rpt_cnt <= '0;
        pulse_q <= 1'b0;
      end else begin
        pulse_q <= 1'b0;
        case (state)
          IDLE: begin
            if (press[j]) begin
              pulse_q <= 1'b1;
              rpt_cnt <= '0;
              state   <= DELAY;
            end
          end
          DELAY: begin
            if (stable[j]) begin
              rpt_cnt <= '0;
              state   <= IDLE;
            end else if (rpt_cnt == DAS_LAST) begin
              pulse_q <= 1'b1;
              rpt_cnt <= '0;
              state   <= REPEAT;
            end else begin
              rpt_cnt <= rpt_cnt + RW'(1);
            end
          end
          REPEAT: begin
            if (stable[j]) begin
              rpt_cnt <= '0;
              state   <= IDLE;
            end else if (rpt_cnt == ARR_LAST) begin
              pulse_q <= 1'b1;
              rpt_cnt <= '0;
            end else begin
              rpt_cnt <= rpt_cnt + RW'(1);
            end
          end
          default: begin
            rpt_cnt <= '0;
            state   <= IDLE;
          end
        endcase
      end
    end

    assign rpt_pulse[j] = pulse_q;
  end

  assign left_final  = rpt_pulse[2];
  assign right_final = rpt_pulse[1];

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      rot_final    <= 1'b0;
      grav_cnt     <= '0;
      tick_gravity <= 1'b0;
      blink_g      <= 1'b0;
    end else begin
      rot_final    <= press[0];
      tick_gravity <= 1'b0;
      if (grav_en) begin
        if (grav_cnt == GRAV_LAST) begin
          grav_cnt     <= '0;
          tick_gravity <= 1'b1;
          blink_g      <= ~blink_g;
        end else begin
          grav_cnt <= grav_cnt + GW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: expected pulse edges are queued per output and
// consumed as the DUT is sampled 1 time unit after each rising edge.
module tb_input_conditioner;

  logic       CLOCK_50;
  logic       resetn;
  logic [2:0] key_n;
  logic       grav_en;
  logic       left_final, right_final, rot_final, tick_gravity, blink_g;

  input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .DAS_CYCLES     (10),
    .ARR_CYCLES     (3),
    .GRAV_CYCLES    (5)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .resetn      (resetn),
    .key_n       (key_n),
    .grav_en     (grav_en),
    .left_final  (left_final),
    .right_final (right_final),
    .rot_final   (rot_final),
    .tick_gravity(tick_gravity),
    .blink_g     (blink_g)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_pass   = 0;
  int rel      = 0;
  bit exp_blink = 1'b0;

  // Expected pulse edges (relative to the current step's edge 0) for each output
  int q_left[$];
  int q_right[$];
  int q_rot[$];
  int q_tick[$];

  task automatic check(input string tag, input int when, input logic [4:0] obs, input logic [4:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s at edge %0d: observed {L,R,ROT,TICK,BLINK}=%b required %b", tag, when, obs, exp);
  endtask

  task automatic run(input int n, input string tag);
    logic [4:0] e;
    for (int k = 0; k < n; k++) begin
      @(posedge CLOCK_50);
      #1;
      rel++;
      e = '0;
      if (q_left.size() > 0 && q_left[0] == rel) begin
        e[4] = 1'b1;
        void'(q_left.pop_front());
      end
      if (q_right.size() > 0 && q_right[0] == rel) begin
        e[3] = 1'b1;
        void'(q_right.pop_front());
      end
      if (q_rot.size() > 0 && q_rot[0] == rel) begin
        e[2] = 1'b1;
        void'(q_rot.pop_front());
      end
      if (q_tick.size() > 0 && q_tick[0] == rel) begin
        e[1] = 1'b1;
        exp_blink = ~exp_blink;
        void'(q_tick.pop_front());
      end
      e[0] = exp_blink;
      check(tag, rel, {left_final, right_final, rot_final, tick_gravity, blink_g}, e);
    end
  endtask

  task automatic check_drained(input string tag);
    int left_over;
    left_over = q_left.size() + q_right.size() + q_rot.size() + q_tick.size();
    n_checks++;
    assert (left_over === 0) n_pass++;
    else $error("FAIL %s: %0d expected pulses never seen, required 0", tag, left_over);
  endtask

  initial begin
    key_n   = 3'b111;
    grav_en = 1'b0;
    resetn  = 1'b1;
    #1 resetn = 1'b0;
    #1 check("reset_state", 0, {left_final, right_final, rot_final, tick_gravity, blink_g}, 5'b0);
    repeat (3) @(negedge CLOCK_50);
    resetn = 1'b1;
    rel = -1;
    run(3, "idle");

    // Left held: initial pulse, DAS, then ARR; release ends the repeat
    key_n[2] = 1'b0;
    rel = -1;
    q_left = '{6, 16, 19, 22, 25, 28, 31, 34};
    run(30, "left_das_arr");
    key_n[2] = 1'b1;
    run(15, "left_release");
    check_drained("left_das_arr_drained");

    // Rotate glitches of 3 cycles never qualify; a long press gives one pulse only
    rel = -1;
    for (int g = 0; g < 5; g++) begin
      key_n[0] = 1'b0;
      run(3, "rot_glitch");
      key_n[0] = 1'b1;
      run(3, "rot_glitch");
    end
    key_n[0] = 1'b0;
    rel = -1;
    q_rot = '{6};
    run(20, "rot_hold");
    key_n[0] = 1'b1;
    run(10, "rot_release");
    check_drained("rot_drained");

    // Right released so the FSM sees it on the very edge the DAS counter is terminal
    key_n[1] = 1'b0;
    rel = -1;
    q_right = '{6};
    run(10, "right_short");
    key_n[1] = 1'b1;
    run(12, "right_no_repeat");
    key_n[1] = 1'b0;
    rel = -1;
    q_right = '{6};
    run(8, "right_repress");
    key_n[1] = 1'b1;
    run(15, "right_repress_release");
    check_drained("right_drained");

    // Gravity: run, hold, resume from the held count
    grav_en = 1'b1;
    rel = 0;
    q_tick = '{5, 10, 22};
    run(12, "grav_run");
    grav_en = 1'b0;
    run(7, "grav_hold");
    grav_en = 1'b1;
    run(5, "grav_resume");
    grav_en = 1'b0;
    run(4, "grav_off");
    check_drained("grav_drained");

    // Left and right pressed together pulse in lockstep; release lands on a terminal ARR edge
    key_n = 3'b001;
    rel = -1;
    q_left  = '{6, 16, 19, 22, 25, 28};
    q_right = '{6, 16, 19, 22, 25, 28};
    run(25, "both_hold");
    key_n = 3'b111;
    run(15, "both_release");
    check_drained("both_drained");

    // Asynchronous reset while left repeats; held key restarts as a fresh press
    key_n[2] = 1'b0;
    rel = -1;
    q_left = '{6, 16, 19};
    run(20, "pre_reset");
    #2 resetn = 1'b0;
    exp_blink = 1'b0;
    #1 check("async_reset", rel, {left_final, right_final, rot_final, tick_gravity, blink_g}, 5'b0);
    repeat (2) @(negedge CLOCK_50);
    resetn = 1'b1;
    rel = -1;
    q_left = '{6, 16, 19, 22, 25, 28};
    run(24, "post_reset_hold");
    key_n[2] = 1'b1;
    run(15, "post_reset_release");
    check_drained("post_reset_drained");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
